// File: rtl/mlaccel_seq.sv
// Instruction sequencer: fetches, runs call/return/jump, forwards the rest.
// Optional fetch/halt trace when MLACCEL_SEQ_TRACE_EN is defined.
module mlaccel_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        smem_valid,
  input  logic        smem_ready,
  output logic [15:0] smem_addr,
  input  logic [31:0] smem_data,
  output logic        comp_valid,
  input  logic        comp_ready,
  output logic [31:0] comp_insn
);
  typedef enum logic [1:0] {
    IDLE, FETCH, EXEC, ISSUE
  } state_t;

  localparam logic [7:0] OP_CALL = 8'h01;
  localparam logic [7:0] OP_RET  = 8'h02;
  localparam logic [7:0] OP_JUMP = 8'h03;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] raddr_q;
  logic        rst_pend_q;
  logic        pend_q;
  logic [31:0] insn_q;
  logic [15:0] stk_q [4];
  logic [1:0]  sp_q;
  logic [2:0]  cnt_q;
  logic        smem_valid_q;
  logic [15:0] smem_addr_q;
  logic        comp_valid_q;
  logic [31:0] comp_insn_q;

  logic [15:0] tgt_d;
  logic [15:0] inc_d;
  logic [15:0] top_d;
  logic [15:0] ra_d;
  logic        is_call;
  logic        is_ret;
  logic        is_jump;
  logic        outst;

  assign tgt_d   = insn_q[31:16];
  assign inc_d   = pc_q + 16'd1;
  assign top_d   = stk_q[sp_q - 2'd1];
  assign ra_d    = start ? addr : raddr_q;
  assign is_call = insn_q[7:0] == OP_CALL;
  assign is_ret  = insn_q[7:0] == OP_RET;
  assign is_jump = insn_q[7:0] == OP_JUMP;
  assign outst   = smem_valid_q | pend_q;

  assign busy       = state_q != IDLE;
  assign smem_valid = smem_valid_q;
  assign smem_addr  = smem_addr_q;
  assign comp_valid = comp_valid_q;
  assign comp_insn  = comp_insn_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      raddr_q      <= '0;
      rst_pend_q   <= 1'b0;
      pend_q       <= 1'b0;
      insn_q       <= '0;
      sp_q         <= '0;
      cnt_q        <= '0;
      smem_valid_q <= 1'b0;
      smem_addr_q  <= '0;
      comp_valid_q <= 1'b0;
      comp_insn_q  <= '0;
      for (int i = 0; i < 4; i++)
        stk_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pc_q         <= addr;
            sp_q         <= '0;
            cnt_q        <= '0;
            state_q      <= FETCH;
            smem_valid_q <= 1'b1;
            smem_addr_q  <= addr;
          end
        end
        FETCH: begin
          if (start) begin
            pc_q  <= addr;
            sp_q  <= '0;
            cnt_q <= '0;
            // a live request must see its ready before a new one goes out
            if (!outst) begin
              smem_valid_q <= 1'b1;
              smem_addr_q  <= addr;
            end else begin
              smem_valid_q <= 1'b0;
              pend_q       <= ~smem_ready;
            end
          end else if (pend_q) begin
            if (smem_ready)
              pend_q <= 1'b0;
          end else if (!smem_valid_q) begin
            smem_valid_q <= 1'b1;
            smem_addr_q  <= pc_q;
          end else if (smem_ready) begin
            smem_valid_q <= 1'b0;
            insn_q       <= smem_data;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (start) begin
            pc_q         <= addr;
            sp_q         <= '0;
            cnt_q        <= '0;
            state_q      <= FETCH;
            smem_valid_q <= 1'b1;
            smem_addr_q  <= addr;
          end else begin
            unique case (1'b1)
              is_call: begin
                stk_q[sp_q]  <= inc_d;
                sp_q         <= sp_q + 2'd1;
                if (cnt_q != 3'd4)
                  cnt_q <= cnt_q + 3'd1;
                pc_q         <= tgt_d;
                state_q      <= FETCH;
                smem_valid_q <= 1'b1;
                smem_addr_q  <= tgt_d;
              end
              is_ret: begin
                if (cnt_q == 3'd0) begin
                  state_q <= IDLE;
                end else begin
                  sp_q         <= sp_q - 2'd1;
                  cnt_q        <= cnt_q - 3'd1;
                  pc_q         <= top_d;
                  state_q      <= FETCH;
                  smem_valid_q <= 1'b1;
                  smem_addr_q  <= top_d;
                end
              end
              is_jump: begin
                pc_q         <= tgt_d;
                state_q      <= FETCH;
                smem_valid_q <= 1'b1;
                smem_addr_q  <= tgt_d;
              end
              default: begin
                comp_valid_q <= 1'b1;
                comp_insn_q  <= insn_q;
                state_q      <= ISSUE;
              end
            endcase
          end
        end
        ISSUE: begin
          if (comp_ready) begin
            comp_valid_q <= 1'b0;
            state_q      <= FETCH;
            smem_valid_q <= 1'b1;
            if (start | rst_pend_q) begin
              rst_pend_q  <= 1'b0;
              pc_q        <= ra_d;
              sp_q        <= '0;
              cnt_q       <= '0;
              smem_addr_q <= ra_d;
            end else begin
              pc_q        <= inc_d;
              smem_addr_q <= inc_d;
            end
          end else if (start) begin
            rst_pend_q <= 1'b1;
            raddr_q    <= addr;
          end
        end
      endcase
    end
  end

`ifdef MLACCEL_SEQ_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset && state_q == EXEC) begin
      $display("trace pc=%h insn=%h", pc_q, insn_q);
      if (!start && is_ret && cnt_q == 3'd0)
        $display("trace halt");
    end
  end
`else
`endif

endmodule

// File: tb/tb_mlaccel_seq.sv
// Directed bench for mlaccel_seq with a fixed-latency memory model.
module tb_mlaccel_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] addr;
  logic        busy;
  logic        smem_valid;
  logic        smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        comp_valid;
  logic        comp_ready;
  logic [31:0] comp_insn;

  logic [31:0] mem [0:65535];
  logic [15:0] fetch_log [$];
  logic [15:0] exp_f [$];
  logic [31:0] comp_log [$];
  int          checks = 0;
  int          failures = 0;
  logic        stable;

  always #5 clock = ~clock;

  mlaccel_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .addr       (addr),
    .busy       (busy),
    .smem_valid (smem_valid),
    .smem_ready (smem_ready),
    .smem_addr  (smem_addr),
    .smem_data  (smem_data),
    .comp_valid (comp_valid),
    .comp_ready (comp_ready),
    .comp_insn  (comp_insn)
  );

  // memory: accepts a request, answers 3 cycles later even if abandoned
  initial begin
    logic        pend;
    logic        was;
    int          lat;
    logic [15:0] ra;
    pend = 1'b0;
    lat = 0;
    ra = '0;
    smem_ready = 1'b0;
    smem_data = '0;
    forever begin
      @(negedge clock);
      was = smem_ready;
      smem_ready = 1'b0;
      if (pend) begin
        lat++;
        if (lat == 3) begin
          smem_ready = 1'b1;
          smem_data = mem[ra];
          fetch_log.push_back(ra);
          pend = 1'b0;
        end
      end else if (smem_valid && !was) begin
        pend = 1'b1;
        lat = 1;
        ra = smem_addr;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #4;
      if (comp_valid && comp_ready)
        comp_log.push_back(comp_insn);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, "_nfetch"}, fetch_log.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < fetch_log.size(); i++)
      chk($sformatf("%s_f%0d", tag, i), {16'd0, fetch_log[i]},
          {16'd0, exp_f[i]});
  endtask

  task automatic clear_logs();
    fetch_log.delete();
    comp_log.delete();
    exp_f.delete();
  endtask

  task automatic pulse_start(input logic [15:0] a);
    @(negedge clock);
    start = 1'b1;
    addr = a;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_start(input string tag, input logic [15:0] a);
    pulse_start(a);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_sv"}, {31'd0, smem_valid}, 32'd1);
    chk({tag, "_sa"}, {16'd0, smem_addr}, {16'd0, a});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_cv(input string tag);
    int n;
    n = 0;
    while (!comp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_cv"}, {31'd0, comp_valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = 32'h0000_0002;
    reset = 1'b1;
    start = 1'b0;
    addr = '0;
    comp_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sv", {31'd0, smem_valid}, 32'd0);
    chk("rst_cv", {31'd0, comp_valid}, 32'd0);
    chk("rst_sa", {16'd0, smem_addr}, 32'd0);
    chk("rst_ci", comp_insn, 32'd0);
    reset = 1'b0;

    // halt on empty-stack return, busy falls two cycles after ready
    clear_logs();
    mem[16'h10] = 32'h0000_0002;
    do_start("t1", 16'h0010);
    repeat (3) @(negedge clock);
    chk("t1_busy_r1", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("t1_busy_r2", {31'd0, busy}, 32'd0);
    exp_f = '{16'h0010};
    chk_fetch("t1");
    chk("t1_ncomp", comp_log.size(), 32'd0);

    // single forwarded instruction
    clear_logs();
    comp_ready = 1'b1;
    mem[16'h10] = 32'hABCD_0040;
    mem[16'h11] = 32'h0000_0002;
    do_start("t2", 16'h0010);
    wait_idle("t2");
    exp_f = '{16'h0010, 16'h0011};
    chk_fetch("t2");
    chk("t2_ncomp", comp_log.size(), 32'd1);
    if (comp_log.size() > 0)
      chk("t2_c0", comp_log[0], 32'hABCD_0040);

    // call and return
    clear_logs();
    mem[16'h10] = 32'h0020_0001;
    mem[16'h11] = 32'h0000_0002;
    mem[16'h20] = 32'h1234_0050;
    mem[16'h21] = 32'h0000_0002;
    do_start("t3", 16'h0010);
    wait_idle("t3");
    exp_f = '{16'h0010, 16'h0020, 16'h0021, 16'h0011};
    chk_fetch("t3");
    chk("t3_ncomp", comp_log.size(), 32'd1);
    if (comp_log.size() > 0)
      chk("t3_c0", comp_log[0], 32'h1234_0050);

    // compute back-pressure for 10 cycles
    clear_logs();
    comp_ready = 1'b0;
    mem[16'h10] = 32'h5566_0077;
    mem[16'h11] = 32'h0000_0002;
    do_start("t4", 16'h0010);
    wait_cv("t4");
    stable = 1'b1;
    repeat (10) begin
      @(negedge clock);
      stable &= (comp_valid === 1'b1) && (comp_insn === 32'h5566_0077)
                && (smem_valid === 1'b0);
    end
    chk("t4_stall", {31'd0, stable}, 32'd1);
    comp_ready = 1'b1;
    @(negedge clock);
    chk("t4_cv_drop", {31'd0, comp_valid}, 32'd0);
    chk("t4_sv_next", {31'd0, smem_valid}, 32'd1);
    chk("t4_sa_next", {16'd0, smem_addr}, 32'h0000_0011);
    wait_idle("t4");
    chk("t4_ncomp", comp_log.size(), 32'd1);

    // five nested calls overflow the 4-deep stack
    clear_logs();
    mem[16'h10] = 32'h0030_0001;
    mem[16'h11] = 32'h1234_0099;
    mem[16'h12] = 32'h0000_0002;
    mem[16'h30] = 32'h0040_0001;
    mem[16'h31] = 32'h0000_0002;
    mem[16'h40] = 32'h0050_0001;
    mem[16'h41] = 32'h0000_0002;
    mem[16'h50] = 32'h0060_0001;
    mem[16'h51] = 32'h0000_0002;
    mem[16'h60] = 32'h0070_0001;
    mem[16'h61] = 32'h0000_0002;
    mem[16'h70] = 32'h0000_0002;
    do_start("t5", 16'h0010);
    wait_idle("t5");
    exp_f = '{16'h0010, 16'h0030, 16'h0040, 16'h0050, 16'h0060,
              16'h0070, 16'h0061, 16'h0051, 16'h0041, 16'h0031};
    chk_fetch("t5");
    chk("t5_ncomp", comp_log.size(), 32'd0);

    // pc wrap and jump
    clear_logs();
    mem[16'hFFFF] = 32'h0000_0060;
    mem[16'h0000] = 32'h0005_0003;
    mem[16'h0005] = 32'h0000_0002;
    do_start("t6", 16'hFFFF);
    wait_idle("t6");
    exp_f = '{16'hFFFF, 16'h0000, 16'h0005};
    chk_fetch("t6");
    chk("t6_ncomp", comp_log.size(), 32'd1);
    if (comp_log.size() > 0)
      chk("t6_c0", comp_log[0], 32'h0000_0060);

    // restart during an outstanding fetch drops its data
    clear_logs();
    mem[16'h10] = 32'h1111_1160;
    mem[16'h11] = 32'h0000_0002;
    mem[16'h20] = 32'h0000_0002;
    do_start("t7", 16'h0010);
    pulse_start(16'h0020);
    wait_idle("t7");
    exp_f = '{16'h0010, 16'h0020};
    chk_fetch("t7");
    chk("t7_ncomp", comp_log.size(), 32'd0);

    // restart during an offer completes the offer first
    clear_logs();
    comp_ready = 1'b0;
    mem[16'h10] = 32'h0000_0077;
    mem[16'h11] = 32'h0000_0002;
    mem[16'h40] = 32'h0000_0002;
    do_start("t8", 16'h0010);
    wait_cv("t8");
    pulse_start(16'h0040);
    repeat (3) @(negedge clock);
    chk("t8_cv_hold", {31'd0, comp_valid}, 32'd1);
    chk("t8_sv_hold", {31'd0, smem_valid}, 32'd0);
    comp_ready = 1'b1;
    @(negedge clock);
    chk("t8_sv", {31'd0, smem_valid}, 32'd1);
    chk("t8_sa", {16'd0, smem_addr}, 32'h0000_0040);
    wait_idle("t8");
    exp_f = '{16'h0010, 16'h0040};
    chk_fetch("t8");
    chk("t8_ncomp", comp_log.size(), 32'd1);

    // reset in the middle of an offer, then a clean run
    clear_logs();
    comp_ready = 1'b0;
    mem[16'h10] = 32'h0000_0044;
    mem[16'h11] = 32'h0000_0002;
    do_start("t9", 16'h0010);
    wait_cv("t9");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t9_cv", {31'd0, comp_valid}, 32'd0);
    chk("t9_busy", {31'd0, busy}, 32'd0);
    chk("t9_sv", {31'd0, smem_valid}, 32'd0);
    reset = 1'b0;
    comp_ready = 1'b1;
    clear_logs();
    do_start("t9b", 16'h0010);
    wait_idle("t9b");
    exp_f = '{16'h0010, 16'h0011};
    chk_fetch("t9b");
    chk("t9b_ncomp", comp_log.size(), 32'd1);
    if (comp_log.size() > 0)
      chk("t9b_c0", comp_log[0], 32'h0000_0044);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
